// File: rtl/wave_former_pkg.sv
// Shared wave former types: NCO control states, config word layout and the
// inverse CORDIC gain constant.
package wave_former_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } nco_state_e;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] phase;
        logic [15:0] amp;
        logic [15:0] div;
    } nco_cfg_t;

    // round(0.607253 * 2^16); treat as an unsigned magnitude.
    localparam logic [15:0] CORDIC_INV_GAIN = 16'h9B75;

endpackage

// File: rtl/dffenr.sv
// Generic D register with clock enable and synchronous active-high reset.
module dffenr #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/nco_divider.sv
// Sample-rate down-counter: ticks at zero, then reloads the period; clr_i
// forces the count to zero so the following cycle ticks.
module nco_divider #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 run_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] count_q, count_d;

    assign tick_o = run_i & (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (run_i) begin
            count_d = (count_q == '0) ? div_i : count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO phase/amplitude source feeding the rotate CORDIC; config applied at a
// phase wrap. Define NCO_GAIN_COMP_EN to pre-scale amplitude by 1/CORDIC gain.
module nco_phase_gen
    import wave_former_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int Z_WIDTH   = 16,
    parameter int XY_WIDTH  = 16,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_WIDTH-1:0] cfg_freq,
    input  logic [Z_WIDTH-1:0]   cfg_phase,
    input  logic [XY_WIDTH-1:0]  cfg_amp,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 sync,
    output logic                 valid_out,
    output logic [XY_WIDTH-1:0]  x_out,
    output logic [XY_WIDTH-1:0]  y_out,
    output logic [Z_WIDTH-1:0]   z_out
);

    localparam int CFG_W = ACC_WIDTH + Z_WIDTH + XY_WIDTH + DIV_WIDTH;

    nco_state_e           state_q, state_d;
    logic [CFG_W-1:0]     act_q, shd_q, act_d, cfg_in;
    logic [XY_WIDTH-1:0]  amp_in;
    logic [ACC_WIDTH-1:0] act_freq, acc_q, acc_d;
    logic [Z_WIDTH-1:0]   act_phase, z_q;
    logic [XY_WIDTH-1:0]  act_amp, x_q;
    logic [DIV_WIDTH-1:0] act_div;
    logic                 valid_q, accept, div_tick, tick, wrap;
    logic                 load_act, load_shd, clr;

`ifdef NCO_GAIN_COMP_EN
    // Operands widened so the product cannot overflow before the >>> 16.
    assign amp_in = XY_WIDTH'(($signed({{17{cfg_amp[XY_WIDTH-1]}}, cfg_amp}) *
                               $signed({{(XY_WIDTH+1){1'b0}}, CORDIC_INV_GAIN})) >>> 16);
`else
    assign amp_in = cfg_amp;
`endif

    assign cfg_in    = {cfg_freq, cfg_phase, amp_in, cfg_div};
    assign act_freq  = act_q[CFG_W-1 -: ACC_WIDTH];
    assign act_phase = act_q[XY_WIDTH+DIV_WIDTH +: Z_WIDTH];
    assign act_amp   = act_q[DIV_WIDTH +: XY_WIDTH];
    assign act_div   = act_q[0 +: DIV_WIDTH];

    assign cfg_ready = (state_q != PENDING);
    assign accept    = cfg_valid & cfg_ready;
    // A sync cycle suppresses the tick; the cleared divider ticks next cycle.
    assign tick      = div_tick & ~sync;
    assign acc_d     = acc_q + act_freq;
    assign wrap      = acc_q[ACC_WIDTH-1] & ~acc_d[ACC_WIDTH-1];

    always_comb begin
        state_d  = state_q;
        act_d    = cfg_in;
        load_act = 1'b0;
        load_shd = 1'b0;
        clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_act = 1'b1;
                    clr      = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (sync) begin
                    clr      = 1'b1;
                    load_act = accept;
                end else if (accept) begin
                    load_shd = 1'b1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (sync || (tick && (wrap || act_freq == '0))) begin
                    clr      = sync;
                    load_act = 1'b1;
                    act_d    = shd_q;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    dffenr #(.WIDTH(CFG_W)) u_act_cfg (
        .clk(clk), .rst(rst), .en_i(en & load_act), .d_i(act_d), .q_o(act_q)
    );

    dffenr #(.WIDTH(CFG_W)) u_shd_cfg (
        .clk(clk), .rst(rst), .en_i(en & load_shd), .d_i(cfg_in), .q_o(shd_q)
    );

    nco_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk(clk), .rst(rst), .en_i(en), .run_i(state_q != IDLE),
        .clr_i(clr), .div_i(act_div), .tick_o(div_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
        end else if (en) begin
            valid_q <= tick;
            if (clr) begin
                acc_q <= '0;
            end else if (tick) begin
                acc_q <= acc_d;
            end
            if (tick) begin
                z_q <= acc_q[ACC_WIDTH-1 -: Z_WIDTH] + act_phase;
                x_q <= act_amp;
            end
        end
    end

    assign valid_out = valid_q;
    assign x_out     = x_q;
    assign y_out     = '0;
    assign z_out     = z_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the NCO.
module tb_nco_phase_gen;
    import wave_former_pkg::*;

    logic        clk = 1'b0;
    logic        en, rst, cfg_valid, sync;
    logic [31:0] cfg_freq;
    logic [15:0] cfg_phase, cfg_amp, cfg_div;
    logic        cfg_ready, valid_out;
    logic [15:0] x_out, y_out, z_out;

    always #5 clk = ~clk;

    nco_phase_gen #(
        .ACC_WIDTH(32), .Z_WIDTH(16), .XY_WIDTH(16), .DIV_WIDTH(16)
    ) dut (
        .clk(clk), .en(en), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_div(cfg_div),
        .sync(sync), .valid_out(valid_out),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

`ifdef NCO_GAIN_COMP_EN
    localparam logic [15:0] X_EXP = 16'h4DB9;
`else
    localparam logic [15:0] X_EXP = 16'h7FFF;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=pending; m_cnt = enabled cycles until next sample.
    int          m_mode, m_cnt;
    logic [31:0] m_acc;
    nco_cfg_t    m_act, m_shd;
    logic        m_valid;
    logic [15:0] m_x, m_z;

    function automatic logic [15:0] ref_amp(input logic [15:0] a);
`ifdef NCO_GAIN_COMP_EN
        longint s, p;
        s = longint'($signed(a));
        p = s * 39797;
        return p[31:16];
`else
        return a;
`endif
    endfunction

    task automatic model_step();
        nco_cfg_t    nc;
        logic        accept, apply;
        logic [32:0] sum;
        nc     = '{freq: cfg_freq, phase: cfg_phase, amp: ref_amp(cfg_amp), div: cfg_div};
        accept = cfg_valid && (m_mode != 2);
        apply  = 1'b0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_acc = '0; m_act = '0; m_shd = '0;
            m_valid = 1'b0; m_x = '0; m_z = '0;
        end else if (en) begin
            if (m_mode == 0) begin
                m_valid = 1'b0;
                if (accept) begin
                    m_act = nc; m_acc = '0; m_cnt = 0; m_mode = 1;
                end
            end else if (sync) begin
                m_valid = 1'b0; m_acc = '0; m_cnt = 0;
                if (m_mode == 2) m_act = m_shd;
                else if (accept) m_act = nc;
                m_mode = 1;
            end else begin
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_z     = m_acc[31:16] + m_act.phase;
                    m_x     = m_act.amp;
                    sum     = {1'b0, m_acc} + {1'b0, m_act.freq};
                    apply   = (m_mode == 2) && (sum[32] || m_act.freq == 0);
                    m_acc   = sum[31:0];
                    m_cnt   = int'(m_act.div);
                end else begin
                    m_valid = 1'b0;
                    m_cnt   = m_cnt - 1;
                end
                if (apply) begin
                    m_act = m_shd; m_mode = 1;
                end else if (m_mode == 1 && accept) begin
                    m_shd = nc; m_mode = 2;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("valid_out", valid_out, m_valid);
        check_eq("x_out", x_out, m_x);
        check_eq("y_out", y_out, 32'd0);
        check_eq("z_out", z_out, m_z);
        check_eq("cfg_ready", cfg_ready, m_mode != 2);
    endtask

    task automatic drive_cfg(input logic [31:0] f, input logic [15:0] p,
                             input logic [15:0] a, input logic [15:0] d);
        cfg_valid = 1'b1; cfg_freq = f; cfg_phase = p; cfg_amp = a; cfg_div = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; sync = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [15:0] zexp[6];
    logic        rexp[6];
    int          nv;

    initial begin
        en = 1'b1; rst = 1'b1; cfg_valid = 1'b0; sync = 1'b0;
        cfg_freq = '0; cfg_phase = '0; cfg_amp = '0; cfg_div = '0;
        step();
        do_reset();
        check_eq("rst_valid", valid_out, 32'd0);
        check_eq("rst_z", z_out, 32'd0);
        check_eq("rst_ready", cfg_ready, 32'd1);

        // Quarter-turn ramp, one sample per cycle.
        drive_cfg(32'h4000_0000, 16'h0000, 16'h7FFF, 16'd0);
        step();
        cfg_valid = 1'b0;
        zexp = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("ramp_valid", valid_out, 32'd1);
            check_eq("ramp_z", z_out, zexp[i]);
        end
        check_eq("ramp_x", x_out, X_EXP);

        // div=3: one strobe in four, z steps a quarter turn per strobe.
        do_reset();
        drive_cfg(32'h4000_0000, 16'h0000, 16'h1234, 16'd3);
        step();
        cfg_valid = 1'b0;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (valid_out) begin
                check_eq("div3_z", z_out, 32'(16'(nv * 16'h4000)));
                nv++;
            end
        end
        check_eq("div3_strobes", nv, 32'd4);

        // Reconfig lands at the wrap tick.
        do_reset();
        drive_cfg(32'h4000_0000, 16'h0000, 16'h0100, 16'd0);
        step();
        cfg_valid = 1'b0;
        step();
        step();
        drive_cfg(32'h2000_0000, 16'h0000, 16'h0200, 16'd0);
        zexp = '{16'h8000, 16'hC000, 16'h0000, 16'h2000, 16'h4000, 16'h6000};
        rexp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step();
            cfg_valid = 1'b0;
            check_eq("reconf_z", z_out, zexp[i]);
            check_eq("reconf_ready", cfg_ready, rexp[i]);
        end

        // sync while pending applies the shadow and restarts the ramp.
        do_reset();
        drive_cfg(32'h4000_0000, 16'h0000, 16'h0100, 16'd0);
        step();
        drive_cfg(32'h4000_0000, 16'h1000, 16'h0300, 16'd0);
        step();
        cfg_valid = 1'b0;
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync_gap", valid_out, 32'd0);
        step();
        check_eq("sync_z0", z_out, 32'h1000);
        check_eq("sync_v0", valid_out, 32'd1);
        step();
        check_eq("sync_z1", z_out, 32'h5000);

        // rst while pending.
        drive_cfg(32'h1000_0000, 16'h0040, 16'h0500, 16'd1);
        step();
        cfg_valid = 1'b0;
        check_eq("pend_ready", cfg_ready, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("prst_x", x_out, 32'd0);
        check_eq("prst_ready", cfg_ready, 32'd1);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (valid_out) nv++;
        end
        check_eq("prst_quiet", nv, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(199, 0) == 0);
            en        = ($urandom_range(4, 0) != 0);
            cfg_valid = ($urandom_range(7, 0) == 0);
            sync      = ($urandom_range(29, 0) == 0);
            cfg_freq  = $urandom_range(32'h7FFF_FFFF, 32'h0800_0000);
            if ($urandom_range(9, 0) == 0) cfg_freq = '0;
            cfg_phase = 16'($urandom);
            cfg_amp   = 16'($urandom);
            cfg_div   = 16'($urandom_range(3, 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Numerically controlled phase/amplitude source for the wave former. It sits directly upstream of the rotate CORDIC and drives its `valid_in`/`x_in`/`y_in`/`z_in` with a phase ramp, a constant amplitude vector and a programmable sample rate. Configuration updates are accepted through a valid/ready handshake. They are applied glitch-free at a phase wrap.

## Interface
- `ACC_WIDTH`, 32: phase accumulator width; full scale = one turn.
- `Z_WIDTH`, 16: output angle width; signed, 2^(Z_WIDTH-1) = pi.
- `XY_WIDTH`, 16: amplitude / vector width, signed.
- `DIV_WIDTH`, 16: sample-rate divider width.
- `clk` in 1: clock.
- `en` in 1: clock enable; when low all state holds.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: config word present.
- `cfg_ready` out 1: config word can be accepted.
- `cfg_freq` in ACC_WIDTH: phase increment per sample, unsigned, must be < 2^(ACC_WIDTH-1).
- `cfg_phase` in Z_WIDTH: phase offset added to every output angle.
- `cfg_amp` in XY_WIDTH: signed amplitude.
- `cfg_div` in DIV_WIDTH: sample period − 1, in enabled cycles.
- `sync` in 1: restart phase and divider.
- `valid_out` out 1: sample strobe.
- `x_out` out XY_WIDTH: amplitude (gain-compensated per Configuration).
- `y_out` out XY_WIDTH: always 0.
- `z_out` out Z_WIDTH: angle = acc[ACC_WIDTH-1 -: Z_WIDTH] + active phase.

## Operation
- All registers update only when `en`=1. The handshake completes on `cfg_valid & cfg_ready & en`.
- States:
  - IDLE (after reset):
    - `cfg_ready`=1, no samples.
    - An accepted config goes into the active registers, acc=0, divider count=0, next state RUN.
  - RUN:
    - `cfg_ready`=1.
    - An accepted config goes into the shadow registers, next state PENDING.
  - PENDING:
    - `cfg_ready`=0.
    - Shadow is copied to active on the first tick whose accumulator update wraps (MSB 1→0), or on the next tick if active freq = 0. Then next state RUN.
- Divider: a down-counter. A tick occurs when count = 0, after which it reloads active div; otherwise it decrements. div=0 gives a tick every enabled cycle.
- On a tick:
  - `valid_out`<=1.
  - `z_out`<=acc slice + active phase, modulo 2^Z_WIDTH.
  - acc<=acc+freq, modulo 2^ACC_WIDTH.
  - `x_out`<=active amp.
- On a non-tick enabled cycle: `valid_out`<=0, other outputs hold.
- `sync` in RUN or PENDING:
  - acc=0 and count=0.
  - Any shadow config is applied immediately, next state RUN.
  - A config accepted in the same cycle as `sync` (RUN only) is applied immediately.
  - The next cycle yields a tick with z = phase.
  - `sync` in IDLE is ignored.
- `rst` mid-operation: return to IDLE, shadow discarded, all outputs to reset values on the next edge.

## Timing
- Reset values: `valid_out`=0, `x_out`=0, `y_out`=0, `z_out`=0, `cfg_ready`=1.
- Config accepted in IDLE at edge N: the first `valid_out`=1 appears after edge N+1, with z = cfg_phase.
- Output latency from a tick decision to `valid_out` is one register stage.
- A wrap-triggered update: the tick carrying the wrap still uses the old config. The following tick uses the new freq/phase/amp/div.
- `en` low: `valid_out` holds its value. The downstream pipeline shares `en`, so no sample is duplicated.

## Configuration
- `NCO_GAIN_COMP_EN`
  - Defined: active amp = (cfg_amp × 16'h9B75) >>> 16, a signed multiply by round(0.607253·2^16), computed at config apply time and stored. This cancels the CORDIC gain. No added latency.
  - Undefined: active amp = cfg_amp unchanged.

## Structure
- The shared package `wave_former_pkg` holds:
  - the state enum (IDLE/RUN/PENDING);
  - the config struct (freq, phase, amp, div);
  - the `CORDIC_INV_GAIN` constant 16'h9B75.
- The `dffenr` register is reused for the active/shadow config.
- One sub-module: `nco_divider`, the sample-rate down-counter with reload and sync-clear. It outputs a tick.

## Test plan
- Config freq=32'h4000_0000, phase=0, amp=16'h7FFF, div=0, macro off -> `z_out` = 0000, 4000, 8000, C000, 0000 on consecutive cycles; `x_out`=7FFF, `y_out`=0.
- Same config with `NCO_GAIN_COMP_EN` -> `x_out`=16'h4DB9.
- div=3 -> `valid_out` high one cycle in four; z advances 16'h4000 per strobe.
- Running freq=32'h4000_0000, then a new config freq=32'h2000_0000 accepted after the z=4000 sample -> z 4000, 8000, C000, then 0000, 2000, 4000; `cfg_ready` low from acceptance until the wrap tick.
- `sync` asserted while z=C000 is pending, with phase=16'h1000 -> next `valid_out` has z=1000; the sequence restarts from there.
- `rst` pulse in PENDING -> all outputs 0 and `cfg_ready`=1 next cycle; no `valid_out` until a new config.
